// File: rtl/mem_ctrl_pkg.sv
// Shared types and default geometry for the burst memory controller.
// No logic; latency and backpressure are defined by the users of these types.
package mem_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/bram_sp.sv
// Single-port synchronous RAM; 1-cycle registered read, write takes effect at the edge.
// No backpressure; contents are never reset.
module bram_sp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_burst_controller.sv
// Burst write/read controller over BRAM; first read beat 2 cycles after command accept.
// Write path stalls on wr_valid gaps; read path holds beats in a 2-entry buffer under rd_ready backpressure.
module mem_burst_controller
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk_mem,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  beats_left;
  logic [1:0]        occ;
  logic              inflight, inflight_last;
  logic [DATA_W:0]   fifo_q [2];
  logic              wptr, rptr;
  logic [DATA_W-1:0] bram_rdata;
  logic              cmd_fire, wr_fire, pop, issue;
  logic [2:0]        pending;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign wr_fire  = wr_valid & wr_ready;
  assign rd_valid = !reset && (occ != 2'd0);
  assign pop      = rd_valid & rd_ready;
  assign busy     = !reset && (state != IDLE);
  assign rd_data  = rd_valid ? fifo_q[rptr][DATA_W-1:0] : '0;
  assign rd_last  = rd_valid ? fifo_q[rptr][DATA_W] : 1'b0;

  // Buffer slots already claimed after this cycle's pop; an issue must never overfill the 2 entries.
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_we ? WRITE : READ;
      end
      WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid && beats_left == '0) state_nxt = IDLE;
      end
      READ: begin
        issue = (pending < 3'd2);
        if (issue && beats_left == '0) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (occ == 2'd0 && !inflight) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      issue     = 1'b0;
    end
  end

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      beats_left    <= '0;
      occ           <= 2'd0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wptr          <= 1'b0;
      rptr          <= 1'b0;
    end else begin
      state         <= state_nxt;
      inflight      <= issue;
      inflight_last <= issue && (beats_left == '0);
      if (cmd_fire) begin
        addr       <= cmd_addr;
        beats_left <= cmd_len;
      end else if (wr_fire || issue) begin
        addr       <= addr + 1'b1;
        beats_left <= beats_left - 1'b1;
      end
      if (inflight) wptr <= ~wptr;
      if (pop) rptr <= ~rptr;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_mem) begin
    if (!reset && inflight) fifo_q[wptr] <= {inflight_last, bram_rdata};
  end

  bram_sp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_bram (
    .clk   (clk_mem),
    .we    (wr_fire),
    .re    (issue),
    .addr  (addr),
    .wdata (wr_data),
    .rdata (bram_rdata)
  );

endmodule

// File: tb/tb_mem_burst_controller.sv
// Directed bench for mem_burst_controller: bursts, wrap, read backpressure, write gaps, reset mid-burst.
module tb_mem_burst_controller;

  logic       clk_mem = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_we = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [3:0] cmd_len = 4'h0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_ready = 1'b0;
  logic       cmd_ready, wr_ready, rd_valid, rd_last, busy;
  logic [7:0] rd_data;

  int total = 0;
  int passed = 0;
  logic [7:0] vec [16];
  logic [7:0] one [16];

  always #5 clk_mem = ~clk_mem;

  mem_burst_controller #(.DATA_W(8), .ADDR_W(8), .LEN_W(4)) dut (
    .clk_mem   (clk_mem),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk_mem);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command and return just after the accept edge.
  task automatic send_cmd(input logic we, input logic [7:0] a, input logic [3:0] len);
    int t;
    cmd_we = we; cmd_addr = a; cmd_len = len; cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin tick(); t++; end
    chk("cmd_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wr_beats(input logic [3:0] len, input logic [7:0] d [16], input int gap);
    int t;
    for (int i = 0; i <= int'(len); i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          wr_valid = 1'b0;
          chk("gap_busy", busy, 1);
          chk("gap_cmd_ready", cmd_ready, 0);
          tick();
        end
      end
      wr_valid = 1'b1;
      wr_data = d[i];
      t = 0;
      while (!wr_ready && t < 20) begin tick(); t++; end
      chk("wr_ready", wr_ready, 1);
      chk("wr_busy", busy, 1);
      chk("wr_cmd_ready", cmd_ready, 0);
      tick();
    end
    wr_valid = 1'b0;
    chk("wr_done_busy", busy, 0);
    chk("wr_done_wr_ready", wr_ready, 0);
  endtask

  // Called just after the accept edge; pat bit k drives rd_ready on the k-th cycle rd_valid is seen.
  task automatic rd_beats(input logic [3:0] len, input logic [7:0] e [16], input logic [15:0] pat,
                          input bit seq, input int stop);
    int got, cyc, vi, t;
    bit stalled;
    logic [7:0] hold_d;
    logic hold_l;
    got = 0; cyc = 0; vi = 0; stalled = 0; hold_d = 8'h00; hold_l = 1'b0;
    while (got <= int'(len) && got < stop && cyc < 300) begin
      if (seq && cyc < 2) chk("first_gap_valid", rd_valid, 0);
      if (stalled) begin
        chk("stall_valid", rd_valid, 1);
        chk("stall_data", rd_data, hold_d);
        chk("stall_last", rd_last, hold_l);
      end
      if (rd_valid) begin
        rd_ready = (vi < 16) ? pat[vi] : 1'b1;
        vi++;
        if (rd_ready) begin
          chk("rd_data", rd_data, e[got]);
          chk("rd_last", rd_last, (got == int'(len)) ? 1 : 0);
          if (seq) chk("beat_cycle", cyc, got + 2);
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          hold_d = rd_data;
          hold_l = rd_last;
        end
      end else begin
        rd_ready = 1'b0;
        stalled = 0;
      end
      tick();
      cyc++;
    end
    if (cyc >= 300) chk("rd_timeout_beats", got, int'(len) + 1);
    rd_ready = 1'b0;
    if (got > int'(len)) begin
      chk("no_extra_beat", rd_valid, 0);
      t = 0;
      while (busy && t < 10) begin tick(); t++; end
      chk("rd_done_busy", busy, 0);
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_data", rd_data, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);

    // 1: burst write then full-rate read
    vec = '{0:8'hA0, 1:8'hA1, 2:8'hA2, 3:8'hA3, default:8'h00};
    send_cmd(1'b1, 8'h10, 4'd3);
    wr_beats(4'd3, vec, 0);
    send_cmd(1'b0, 8'h10, 4'd3);
    rd_beats(4'd3, vec, 16'hFFFF, 1'b1, 99);

    // 2: write across the top of memory, then single-beat reads
    vec = '{0:8'h01, 1:8'h02, 2:8'h03, 3:8'h04, default:8'h00};
    send_cmd(1'b1, 8'hFE, 4'd3);
    wr_beats(4'd3, vec, 0);
    one = '{0:8'h01, default:8'h00};
    send_cmd(1'b0, 8'hFE, 4'd0);
    rd_beats(4'd0, one, 16'hFFFF, 1'b1, 99);
    one = '{0:8'h02, default:8'h00};
    send_cmd(1'b0, 8'hFF, 4'd0);
    rd_beats(4'd0, one, 16'hFFFF, 1'b1, 99);
    one = '{0:8'h03, default:8'h00};
    send_cmd(1'b0, 8'h00, 4'd0);
    rd_beats(4'd0, one, 16'hFFFF, 1'b1, 99);
    one = '{0:8'h04, default:8'h00};
    send_cmd(1'b0, 8'h01, 4'd0);
    rd_beats(4'd0, one, 16'hFFFF, 1'b1, 99);

    // 3: 8-beat read under rd_ready pattern 1,0,0,1,0,1,1,...
    vec = '{0:8'h31, 1:8'h32, 2:8'h33, 3:8'h34, 4:8'h35, 5:8'h36, 6:8'h37, 7:8'h38, default:8'h00};
    send_cmd(1'b1, 8'h20, 4'd7);
    wr_beats(4'd7, vec, 0);
    send_cmd(1'b0, 8'h20, 4'd7);
    rd_beats(4'd7, vec, 16'hFFE9, 1'b0, 99);

    // 4: 3-beat write with 3-cycle gaps over a 4-word background
    vec = '{0:8'h11, 1:8'h22, 2:8'h33, 3:8'h44, default:8'h00};
    send_cmd(1'b1, 8'h40, 4'd3);
    wr_beats(4'd3, vec, 0);
    vec = '{0:8'h55, 1:8'h66, 2:8'h77, default:8'h00};
    send_cmd(1'b1, 8'h40, 4'd2);
    wr_beats(4'd2, vec, 3);
    chk("gapwr_cmd_ready", cmd_ready, 1);
    vec = '{0:8'h55, 1:8'h66, 2:8'h77, 3:8'h44, default:8'h00};
    send_cmd(1'b0, 8'h40, 4'd3);
    rd_beats(4'd3, vec, 16'hFFFF, 1'b1, 99);

    // 5: reset after two beats of an 8-beat read
    vec = '{0:8'h31, 1:8'h32, 2:8'h33, 3:8'h34, 4:8'h35, 5:8'h36, 6:8'h37, 7:8'h38, default:8'h00};
    send_cmd(1'b0, 8'h20, 4'd7);
    rd_beats(4'd7, vec, 16'hFFFF, 1'b1, 2);
    reset = 1'b1;
    tick();
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_rd_last", rd_last, 0);
    reset = 1'b0;
    tick();
    chk("midrst_rel_cmd_ready", cmd_ready, 1);
    chk("midrst_rel_rd_valid", rd_valid, 0);
    send_cmd(1'b0, 8'h20, 4'd7);
    rd_beats(4'd7, vec, 16'hFFFF, 1'b1, 99);

    // 6: read command held during a write burst
    vec = '{0:8'h5A, 1:8'hA5, default:8'h00};
    send_cmd(1'b1, 8'h60, 4'd1);
    cmd_we = 1'b0; cmd_addr = 8'h60; cmd_len = 4'd1; cmd_valid = 1'b1;
    wr_beats(4'd1, vec, 1);
    chk("held_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("held_accept_busy", busy, 1);
    rd_beats(4'd1, vec, 16'hFFFF, 1'b1, 99);
    tick();
    chk("held_once_busy", busy, 0);
    chk("held_once_rd_valid", rd_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
